// File: rtl/sub16_if.sv
// Valid/ready stream bundle for sub16_pipe: operand pair in, difference out.
// The zero/ovf flag signals exist only when SUB16_FLAGS_EN is defined.
interface sub16_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             borrow;
`ifdef SUB16_FLAGS_EN
    logic             zero;
    logic             ovf;
`endif

    // master: operand producer and result consumer; slave: the subtractor
    modport master (
        output in_valid,
        input  in_ready,
        output a,
        output b,
        input  out_valid,
        output out_ready,
        input  d,
        input  borrow
`ifdef SUB16_FLAGS_EN
        ,
        input  zero,
        input  ovf
`endif
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  a,
        input  b,
        output out_valid,
        input  out_ready,
        output d,
        output borrow
`ifdef SUB16_FLAGS_EN
        ,
        output zero,
        output ovf
`endif
    );
endinterface

// File: rtl/sub16_pipe.sv
// Pipelined subtractor d = a - b (a + ~b + 1), one SLICE-bit carry slice per stage,
// valid/ready backpressure per stage. Optional zero/ovf flags with SUB16_FLAGS_EN.
module sub16_pipe #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic   clk,
    input  logic   rst,
    sub16_if.slave bus
);
    // WIDTH must be a multiple of SLICE
    localparam int STAGES = WIDTH / SLICE;

    // Operands shift right one slice per stage so the live slice always sits at
    // [SLICE-1:0]; results shift in from the top so stage STAGES holds the full d.
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_c;
    logic [WIDTH-1:0]  r_d [STAGES];
    logic [WIDTH-1:0]  r_a [STAGES];
    logic [WIDTH-1:0]  r_b [STAGES];

    logic [STAGES-1:0] w_rdy;
    logic [STAGES-1:0] w_v_next;
    logic [STAGES-1:0] w_cin;
    logic [SLICE-1:0]  w_op_a   [STAGES];
    logic [SLICE-1:0]  w_op_b   [STAGES];
    logic [SLICE:0]    w_sum    [STAGES];
    logic [WIDTH-1:0]  w_d_next [STAGES];
    logic [WIDTH-1:0]  w_a_next [STAGES];
    logic [WIDTH-1:0]  w_b_next [STAGES];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            // A stage can load when downstream can move or any stage from here on is empty
            assign w_rdy[gi] = bus.out_ready | ~(&r_valid[STAGES-1:gi]);

            if (gi == 0) begin : g_first
                assign w_v_next[gi] = bus.in_valid;
                assign w_op_a[gi]   = bus.a[SLICE-1:0];
                assign w_op_b[gi]   = bus.b[SLICE-1:0];
                assign w_cin[gi]    = 1'b1;
                assign w_a_next[gi] = bus.a >> SLICE;
                assign w_b_next[gi] = bus.b >> SLICE;
                assign w_d_next[gi] = {w_sum[gi][SLICE-1:0], {(WIDTH-SLICE){1'b0}}};
            end else begin : g_rest
                assign w_v_next[gi] = r_valid[gi-1];
                assign w_op_a[gi]   = r_a[gi-1][SLICE-1:0];
                assign w_op_b[gi]   = r_b[gi-1][SLICE-1:0];
                assign w_cin[gi]    = r_c[gi-1];
                assign w_a_next[gi] = r_a[gi-1] >> SLICE;
                assign w_b_next[gi] = r_b[gi-1] >> SLICE;
                assign w_d_next[gi] = {w_sum[gi][SLICE-1:0], r_d[gi-1][WIDTH-1:SLICE]};
            end

            assign w_sum[gi] = {1'b0, w_op_a[gi]} + {1'b0, ~w_op_b[gi]}
                             + {{SLICE{1'b0}}, w_cin[gi]};
        end
    endgenerate

    // Carry registers reset to 1 so the idle borrow output reads 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_c     <= '1;
            for (int s = 0; s < STAGES; s++) begin
                r_d[s] <= '0;
                r_a[s] <= '0;
                r_b[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (w_rdy[s]) begin
                    r_valid[s] <= w_v_next[s];
                    r_c[s]     <= w_sum[s][SLICE];
                    r_d[s]     <= w_d_next[s];
                    r_a[s]     <= w_a_next[s];
                    r_b[s]     <= w_b_next[s];
                end
            end
        end
    end

    assign bus.in_ready  = w_rdy[0] & ~rst;
    assign bus.out_valid = r_valid[STAGES-1];
    assign bus.d         = r_d[STAGES-1];
    assign bus.borrow    = ~r_c[STAGES-1];

`ifdef SUB16_FLAGS_EN
    logic r_zero;
    logic r_ovf;

    // The top operand slice still carries a[MSB] and b[MSB] in its top bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_rdy[STAGES-1]) begin
            r_zero <= (w_d_next[STAGES-1] == '0);
            r_ovf  <= (w_op_a[STAGES-1][SLICE-1] != w_op_b[STAGES-1][SLICE-1])
                   && (w_sum[STAGES-1][SLICE-1] != w_op_a[STAGES-1][SLICE-1]);
        end
    end

    assign bus.zero = r_zero;
    assign bus.ovf  = r_ovf;
`endif
endmodule

// File: tb/tb_sub16_pipe.sv
// Self-checking bench for sub16_pipe: directed vector table, latency/streaming/
// backpressure/reset sequences and a random run against a queue-based model.
module tb_sub16_pipe;
    localparam int STAGES = 4;

    logic clk;
    logic rst;

    sub16_if #(.WIDTH(16)) bus ();

    sub16_pipe #(.WIDTH(16), .SLICE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic        borrow;
        logic        zero;
        logic        ovf;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   n_out    = 0;
    int   n_in     = 0;
    op_t  q[$];
    logic        stall_prev = 1'b0;
    logic [15:0] held_d;
    logic        held_borrow;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; sample and book-keep, then advance.
    task automatic cycle();
        op_t         op;
        logic [15:0] exp_d;
        int          sdiff;
        #2;
        if (!rst) begin
            chk("in_ready", bus.in_ready, !(q.size() == STAGES && !bus.out_ready));
            if (q.size() == 0) chk("idle_out_valid", bus.out_valid, 1'b0);
            if (stall_prev) begin
                chk("stall_valid", bus.out_valid, 1'b1);
                chk("stall_d", bus.d, held_d);
                chk("stall_borrow", bus.borrow, held_borrow);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=d:0x%0h required=none", bus.d);
                end else begin
                    op    = q.pop_front();
                    exp_d = op.a - op.b;
                    sdiff = int'($signed(op.a)) - int'($signed(op.b));
                    chk("d", bus.d, exp_d);
                    chk("borrow", bus.borrow, op.a < op.b);
`ifdef SUB16_FLAGS_EN
                    chk("zero", bus.zero, exp_d == 16'h0);
                    chk("ovf", bus.ovf, (sdiff > 32767) || (sdiff < -32768));
`endif
                    n_out++;
                    $display("result a=%h b=%h d=%h borrow=%b", op.a, op.b, bus.d, bus.borrow);
                end
            end
            stall_prev  = bus.out_valid && !bus.out_ready;
            held_d      = bus.d;
            held_borrow = bus.borrow;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back({bus.a, bus.b});
                n_in++;
            end
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            stall_prev = 1'b0;
        end
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   lat;
        int   base;
        int   base_in;
        int   guard;

        vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h7FFF, 16'h8000, 16'hFFFF, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        // Reset state
        cycle();
        cycle();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_d", bus.d, 16'h0);
        chk("rst_borrow", bus.borrow, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1'b1);
        cycle();

        // Directed single operations: latency, value, one-cycle pulse
        foreach (vecs[i]) begin
            bus.in_valid  = 1'b1;
            bus.a         = vecs[i].a;
            bus.b         = vecs[i].b;
            bus.out_ready = 1'b1;
            cycle();
            bus.in_valid = 1'b0;
            lat = 1;
            while (!bus.out_valid && lat < 12) begin
                cycle();
                lat++;
            end
            chk("latency", lat, STAGES);
            chk("vec_d", bus.d, vecs[i].d);
            chk("vec_borrow", bus.borrow, vecs[i].borrow);
`ifdef SUB16_FLAGS_EN
            chk("vec_zero", bus.zero, vecs[i].zero);
            chk("vec_ovf", bus.ovf, vecs[i].ovf);
`endif
            cycle();
            chk("pulse_end", bus.out_valid, 1'b0);
        end

        // Streaming: 8 back-to-back pairs, one result per cycle after the latency
        base = n_out;
        bus.out_ready = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            bus.in_valid = (t <= 8);
            bus.a        = 16'((t - 1) * 16'h1111);
            bus.b        = 16'h0101;
            if (t <= 8) begin
                #1;
                chk("stream_in_ready", bus.in_ready, 1'b1);
            end
            cycle();
            chk("stream_count", n_out - base, (t > 4) ? ((t - 4 > 8) ? 8 : t - 4) : 0);
        end

        // Backpressure: continuous stream, out_ready low for 6 cycles
        base    = n_out;
        base_in = n_in;
        for (int t = 0; t < 18; t++) begin
            bus.in_valid  = 1'b1;
            bus.a         = 16'($urandom);
            bus.b         = 16'($urandom);
            bus.out_ready = !(t >= 5 && t < 11);
            if (t >= 5 && t < 11) begin
                #1;
                chk("bp_in_ready", bus.in_ready, 1'b0);
            end
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            cycle();
            guard++;
        end
        chk("bp_no_loss", n_out - base, n_in - base_in);

        // Reset with three operations in flight
        for (int t = 0; t < 3; t++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'h1000 + 16'(t);
            bus.b        = 16'h0001;
            cycle();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_d", bus.d, 16'h0);
        chk("midrst_borrow", bus.borrow, 1'b0);
        base = n_out;
        for (int t = 0; t < 8; t++) cycle();
        chk("midrst_no_leak", n_out - base, 0);

        // Randomized traffic against the model
        for (int t = 0; t < 400; t++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.a = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       bus.b = bus.a;
                1:       bus.b = bus.a + 16'h1;
                2:       bus.b = 16'hFFFF;
                3:       bus.a = 16'h8000;
                default: bus.b = 16'($urandom);
            endcase
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            cycle();
            guard++;
        end
        chk("drain_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
